// File: rtl/vfpu_stream_sequencer_pkg.sv
// vfpu_package: shared state enum, cfg field slices and streamer control/flag types for the VFPU sequencer
package vfpu_package;
  localparam int NB_STREAMS_DEF  = 3;
  localparam int LINE_STRIDE_MSB = 31;
  localparam int LINE_STRIDE_LSB = 16;
  localparam int LINE_LENGTH_MSB = 15;
  localparam int LINE_LENGTH_LSB = 0;
  localparam int FEAT_STRIDE_MSB = 31;
  localparam int FEAT_STRIDE_LSB = 16;
  localparam int FEAT_LENGTH_MSB = 15;
  localparam int FEAT_LENGTH_LSB = 0;
  localparam int FEAT_ROLL_MSB   = 15;
  localparam int FEAT_ROLL_LSB   = 0;
  localparam int LOOP_OUTER_BIT  = 16;
  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_LOAD, SEQ_START, SEQ_RUN, SEQ_NEXT, SEQ_DONE
  } seq_state_t;
  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  line_length_remainder;
  } addressgen_ctrl_t;
  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } ctrl_sourcesink_t;
  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;
endpackage

// File: rtl/vfpu_stream_shadow.sv
// vfpu_stream_shadow: per-stream job configuration snapshot with iteration base-address accumulator
module vfpu_stream_shadow
  import vfpu_package::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [31:0]      i_base,
  input  logic [31:0]      i_stride,
  input  logic [31:0]      i_line_cfg,
  input  logic [31:0]      i_feat_cfg,
  input  logic [31:0]      i_roll_cfg,
  input  logic [31:0]      i_trans_size,
  output addressgen_ctrl_t o_ag
);
  logic [31:0] r_base, r_stride, r_line, r_feat, r_trans;
  logic [LOOP_OUTER_BIT:0] r_roll;
  logic w_unused;
  assign w_unused = ^i_roll_cfg[31:LOOP_OUTER_BIT+1];
  // Snapshot on load, then step the base by the stride once per finished iteration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base   <= '0;
      r_stride <= '0;
      r_line   <= '0;
      r_feat   <= '0;
      r_roll   <= '0;
      r_trans  <= '0;
    end else if (i_load) begin
      r_base   <= i_base;
      r_stride <= i_stride;
      r_line   <= i_line_cfg;
      r_feat   <= i_feat_cfg;
      r_roll   <= i_roll_cfg[LOOP_OUTER_BIT:0];
      r_trans  <= i_trans_size;
    end else if (i_adv) begin
      r_base   <= r_base + r_stride;
    end
  end
  // Addressgen view of the snapshot; realignment is never used
  always_comb begin
    o_ag             = '0;
    o_ag.base_addr   = r_base;
    o_ag.trans_size  = r_trans;
    o_ag.line_stride = r_line[LINE_STRIDE_MSB:LINE_STRIDE_LSB];
    o_ag.line_length = r_line[LINE_LENGTH_MSB:LINE_LENGTH_LSB];
    o_ag.feat_stride = r_feat[FEAT_STRIDE_MSB:FEAT_STRIDE_LSB];
    o_ag.feat_length = r_feat[FEAT_LENGTH_MSB:FEAT_LENGTH_LSB];
    o_ag.feat_roll   = r_roll[FEAT_ROLL_MSB:FEAT_ROLL_LSB];
    o_ag.loop_outer  = r_roll[LOOP_OUTER_BIT];
  end
endmodule

// File: rtl/vfpu_stream_sequencer.sv
// vfpu_stream_sequencer: replays a streamer job N times with per-stream base strides; watchdog enabled by VFPU_SEQ_TIMEOUT_EN
module vfpu_stream_sequencer
  import vfpu_package::*;
#(
  parameter int NB_OPERANDS    = 2,
  parameter int ITER_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [NB_OPERANDS:0][31:0]           base_addr_i,
  input  logic [NB_OPERANDS:0][31:0]           iter_stride_i,
  input  logic [NB_OPERANDS:0][31:0]           line_cfg_i,
  input  logic [NB_OPERANDS:0][31:0]           feat_cfg_i,
  input  logic [NB_OPERANDS:0][31:0]           roll_cfg_i,
  input  logic [31:0]                          trans_size_i,
  input  logic [ITER_WIDTH-1:0]                n_iter_i,
  output ctrl_sourcesink_t [NB_OPERANDS-1:0]   source_ctrl_o,
  input  flags_sourcesink_t [NB_OPERANDS-1:0]  source_flags_i,
  output ctrl_sourcesink_t                     sink_ctrl_o,
  input  flags_sourcesink_t                    sink_flags_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [ITER_WIDTH-1:0]                iter_o,
  output logic                                 err_o
);
  localparam int NS = NB_OPERANDS + 1;
  seq_state_t r_state, w_next;
  logic [NS-1:0] r_done, w_flag_done, w_ready_unused;
  logic [ITER_WIDTH-1:0] r_iter, r_n_iter;
  logic w_rst, w_load, w_adv, w_last, w_all_done, w_tmo, w_unused;
  addressgen_ctrl_t [NS-1:0] w_ag;
  assign w_rst      = rst_i | clear_i;
  assign w_load     = r_state == SEQ_LOAD;
  assign w_last     = r_iter == r_n_iter - ITER_WIDTH'(1);
  assign w_adv      = (r_state == SEQ_NEXT) && !w_last;
  assign w_all_done = &(r_done | w_flag_done);
  assign busy_o     = r_state != SEQ_IDLE;
  assign done_o     = r_state == SEQ_DONE;
  assign iter_o     = r_iter;
  for (genvar s = 0; s < NS; s++) begin : g_stream
    if (s < NB_OPERANDS) begin : g_src
      assign w_flag_done[s]    = source_flags_i[s].done;
      assign w_ready_unused[s] = source_flags_i[s].ready_start;
      assign source_ctrl_o[s]  = '{req_start: r_state == SEQ_START, addressgen_ctrl: w_ag[s]};
    end else begin : g_snk
      assign w_flag_done[s]    = sink_flags_i.done;
      assign w_ready_unused[s] = sink_flags_i.ready_start;
      assign sink_ctrl_o       = '{req_start: r_state == SEQ_START, addressgen_ctrl: w_ag[s]};
    end
    vfpu_stream_shadow u_shadow (
      .clk_i       (clk_i),
      .rst_i       (w_rst),
      .i_load      (w_load),
      .i_adv       (w_adv),
      .i_base      (base_addr_i[s]),
      .i_stride    (iter_stride_i[s]),
      .i_line_cfg  (line_cfg_i[s]),
      .i_feat_cfg  (feat_cfg_i[s]),
      .i_roll_cfg  (roll_cfg_i[s]),
      .i_trans_size(trans_size_i),
      .o_ag        (w_ag[s])
    );
  end
  // State register, iteration counter and per-stream completion bits
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state  <= SEQ_IDLE;
      r_done   <= '0;
      r_iter   <= '0;
      r_n_iter <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_iter   <= '0;
        r_n_iter <= (n_iter_i == '0) ? ITER_WIDTH'(1) : n_iter_i;
      end
      if (w_adv) r_iter <= r_iter + ITER_WIDTH'(1);
      r_done <= (r_state == SEQ_START) ? '0 : (r_state == SEQ_RUN) ? (r_done | w_flag_done) : r_done;
    end
  end
  // Next-state: a done pulse arriving with the last missing bit completes the iteration
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEQ_IDLE:  w_next = start_i ? SEQ_LOAD : SEQ_IDLE;
      SEQ_LOAD:  w_next = SEQ_START;
      SEQ_START: w_next = SEQ_RUN;
      SEQ_RUN:   w_next = w_all_done ? SEQ_NEXT : w_tmo ? SEQ_DONE : SEQ_RUN;
      SEQ_NEXT:  w_next = w_last ? SEQ_DONE : SEQ_START;
      SEQ_DONE:  w_next = SEQ_IDLE;
      default:   w_next = SEQ_IDLE;
    endcase
  end
`ifdef VFPU_SEQ_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic r_err;
  assign w_tmo    = (r_state == SEQ_RUN) && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err_o    = r_err;
  assign w_unused = ^w_ready_unused;
  // Watchdog counts RUN cycles of the current iteration; the error stays until the next accepted start
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == SEQ_RUN) ? r_tmo_cnt + 32'd1 : '0;
      r_err     <= (r_state == SEQ_IDLE && start_i) ? 1'b0 : (w_tmo && !w_all_done) ? 1'b1 : r_err;
    end
  end
`else
  assign w_tmo    = 1'b0;
  assign err_o    = 1'b0;
  assign w_unused = ^{w_ready_unused, 32'(TIMEOUT_CYCLES)};
`endif
endmodule

// File: doc/vfpu_stream_sequencer.md
Name: vfpu_stream_sequencer

Overview:
- Parametrised multi-iteration job sequencer for the VFPU HWPE datapath; sits between the register-file outputs of the HWPE slave and the source/sink streamers.
- Drives addressgen control for NB_OPERANDS source streams and one sink stream.
- Replays a job N_ITER times, advancing each stream's base address by a per-stream stride, and waits for every stream's done before the next iteration.
- Raises done once, only after the last iteration completes.

Parameters:
- NB_OPERANDS, 2, number of source streams; the total stream count is NB_OPERANDS+1, with the sink as the last index.
- ITER_WIDTH, 16, width of the iteration count and counter.
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles per iteration; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear from the HWPE slave; same effect as reset.
- start_i  in  1  single-cycle job start pulse.
- base_addr_i  in  (NB_OPERANDS+1)x32  initial base address per stream.
- iter_stride_i  in  (NB_OPERANDS+1)x32  base-address increment per iteration, per stream.
- line_cfg_i  in  (NB_OPERANDS+1)x32  bits [31:16] line_stride, bits [15:0] line_length.
- feat_cfg_i  in  (NB_OPERANDS+1)x32  bits [31:16] feat_stride, bits [15:0] feat_length.
- roll_cfg_i  in  (NB_OPERANDS+1)x32  bit [16] loop_outer, bits [15:0] feat_roll.
- trans_size_i  in  32  transfer size, shared by all streams.
- n_iter_i  in  ITER_WIDTH  iteration count; 0 is treated as 1.
- source_ctrl_o  out  NB_OPERANDS x ctrl_sourcesink_t  source streamer control.
- source_flags_i  in  NB_OPERANDS x flags_sourcesink_t  source streamer flags.
- sink_ctrl_o  out  ctrl_sourcesink_t  sink streamer control.
- sink_flags_i  in  flags_sourcesink_t  sink streamer flags.
- busy_o  out  1  high from LOAD through DONE.
- done_o  out  1  single-cycle pulse when the job completes.
- iter_o  out  ITER_WIDTH  index of the current iteration.
- err_o  out  1  sticky timeout flag; used only with the optional feature.

Behaviour:
- Reset or clear_i: the FSM goes to IDLE. All outputs are 0, including every req_start and every addressgen field. Shadow registers, done bits and the counter are all 0.
- FSM states and transitions:
  - IDLE to LOAD on start_i; start_i is ignored in every other state.
  - LOAD (1 cycle): latches base_addr_i, iter_stride_i, all cfg inputs, trans_size_i and max(n_iter_i,1) into shadow registers. iter_o is set to 0.
  - START (1 cycle): req_start=1 on all streams; per-stream done bits are cleared.
  - RUN: each stream's done bit is set on that stream's flags.done pulse. When all bits are set, go to NEXT. A done pulse arriving in the same cycle as the last missing bit still counts.
  - NEXT (1 cycle): if iter_o == n_iter-1, go to DONE. Otherwise every shadow base += stride, with 32-bit modulo wrap and no saturation; iter_o increments; go to START.
  - DONE (1 cycle): done_o=1, then go to IDLE.
- Addressgen fields are driven from the shadow registers, never directly from the inputs; input changes mid-job have no effect. realign_type=0 and line_length_remainder=0 always.
- Latency: start_i at cycle t gives req_start at t+2. A single-iteration job gives done_o exactly 2 cycles after the last stream done is captured.
- flags.done pulses seen outside RUN are ignored.
- Reset or clear in any state aborts the job immediately; no done_o is produced.

Optional Feature:
- Macro VFPU_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in RUN and resets in START.
  - On reaching TIMEOUT_CYCLES, the FSM sets err_o and goes to DONE, so done_o still pulses.
  - err_o clears on the next start_i, reset or clear_i.
- Without the macro: no counter is built, err_o is tied to 0, and RUN waits indefinitely.

Decomposition:
- Shared package vfpu_package holds:
  - The seq_state_t enum.
  - The cfg field-slice constants: LINE_STRIDE_MSB/LSB, FEAT_* and LOOP_OUTER_BIT.
  - NB_STREAMS_DEF.
- One natural sub-module, vfpu_stream_shadow: per-stream shadow registers with the base-address accumulator. It is instantiated NB_OPERANDS+1 times in a generate loop.

Test Plan:
- n_iter=1, base={0x1000,0x2000,0x3000}, dones at cycles 10/12/15 → req_start at cycle 2; done_o at cycle 17; busy_o low after it.
- n_iter=3, strides={0x40,0x40,0x80} → three req_start pulses; sink base_addr = 0x3000, 0x3080, 0x3100; iter_o = 0, 1, 2; exactly one done_o.
- n_iter=0 → behaves exactly as n_iter=1.
- All three stream dones in the same cycle; an extra sink done pulse while in IDLE → iteration completes; the IDLE pulse has no effect.
- clear_i asserted in RUN during iteration 1 of 3 → IDLE on the next cycle; all ctrl outputs 0; no done_o. A new start_i restarts from iteration 0.
- With VFPU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, one source never signals done → err_o=1 and done_o pulse about 21 cycles after START; err_o clears on the next start_i.
